// File: rtl/capture_ctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_ctl_pkg : state encodings and counter sizing for capture_ctl |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package capture_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2,
    ST_POST = 2'd3
  } state_t;

  // One extra bit so a full-buffer post-trigger count of 2^aw fits.
  localparam int CNT_EXTRA_BITS = 1;

  function automatic int cnt_width(input int addr_w);
    return addr_w + CNT_EXTRA_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_ctl_if : control, sample and RAM write-port bundle           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface capture_ctl_if #(
  parameter int aw = 8,
  parameter int dw = 8
);

  logic          arm;
  logic [aw-1:0] pre_count;
  logic [dw-1:0] din;
  logic          din_valid;
  logic          trig;
  logic [aw-1:0] ram_addr;
  logic [dw-1:0] ram_data;
  logic          ram_wen;
  logic          busy;
  logic          done;
  logic [aw-1:0] trig_addr;

  modport master (
    output arm, pre_count, din, din_valid, trig,
    input  ram_addr, ram_data, ram_wen, busy, done, trig_addr
  );

  modport slave (
    input  arm, pre_count, din, din_valid, trig,
    output ram_addr, ram_data, ram_wen, busy, done, trig_addr
  );

endinterface
`default_nettype wire

// File: rtl/capture_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_ctl : pre/post-trigger capture into a circular RAM buffer    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module capture_ctl
  import capture_ctl_pkg::*;
#(
  parameter int aw = 8,
  parameter int dw = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  capture_ctl_if.slave      bus
);

  localparam int            CW    = cnt_width(aw);
  localparam logic [CW-1:0] DEPTH = {1'b1, {aw{1'b0}}};

  state_t        state_q, state_d;
  logic [aw-1:0] wptr_q, wptr_d;
  logic [aw-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [aw-1:0] ram_addr_q, ram_addr_d;
  logic [dw-1:0] ram_data_q, ram_data_d;
  logic          ram_wen_q, ram_wen_d;
  logic          done_q, done_d;
  logic [aw-1:0] trig_addr_q, trig_addr_d;

  logic [CW-1:0] post_total;
  logic [CW-1:0] cnt_inc;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wen_q   <= 1'b0;
      done_q      <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wen_q   <= ram_wen_d;
      done_q      <= done_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_wen_d   = 1'b0;
    done_d      = done_q;
    trig_addr_d = trig_addr_q;
    accept      = 1'b0;
    post_total  = DEPTH - {1'b0, pre_q};
    cnt_inc     = cnt_q + CW'(1);

    if (bus.arm) begin
      // A sample arriving with arm belongs to no capture and is dropped.
      pre_d   = bus.pre_count;
      wptr_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = (bus.pre_count != '0) ? ST_FILL : ST_WAIT;
    end else begin
      accept = bus.din_valid && (state_q != ST_IDLE);
      if (accept) begin
        ram_wen_d  = 1'b1;
        ram_addr_d = wptr_q;
        ram_data_d = bus.din;
        wptr_d     = wptr_q + aw'(1);
      end

      case (state_q)
        ST_FILL: begin
          if (accept) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, pre_q}) begin
              cnt_d   = '0;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (accept && bus.trig) begin
            trig_addr_d = wptr_q;
            cnt_d       = CW'(1);
            // The trigger sample alone can close the capture when pre_count = 2^aw-1.
            if (post_total == CW'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (accept) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_total) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.done      = done_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_capture_ctl.sv
`default_nettype none
// Directed bench for capture_ctl (aw=4, dw=8); a behavioural RAM records the write port.
module tb_capture_ctl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  capture_ctl_if #(.aw(AW), .dw(DW)) bus ();

  capture_ctl #(.aw(AW), .dw(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [16];
  logic [7:0] cnt = 8'd0;
  int n_pass  = 0;
  int n_total = 0;

  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_data;
  end

  // din follows a free-running count; outputs are observed 1ns after the edge.
  task automatic step(input logic a, input logic v, input logic t);
    bus.arm       = a;
    bus.din_valid = v;
    bus.trig      = t;
    bus.din       = cnt;
    @(posedge clk);
    #1;
    cnt = cnt + 8'd1;
  endtask

  // Aligns the count so the first sample after arm carries value 0.
  task automatic do_arm(input logic [3:0] pc);
    bus.pre_count = pc;
    cnt = 8'hff;
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if ({bus.busy, bus.done, bus.ram_wen} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.ram_wen});
    else n_pass++;
    n_total++;
    if (bus.ram_addr !== 4'd0) $display("FAIL reset_ram_addr: got %0d expected 0", bus.ram_addr);
    else n_pass++;
    n_total++;
    if (bus.ram_data !== 8'd0) $display("FAIL reset_ram_data: got %0d expected 0", bus.ram_data);
    else n_pass++;
    n_total++;
    if (bus.trig_addr !== 4'd0) $display("FAIL reset_trig_addr: got %0d expected 0", bus.trig_addr);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_pretrig();
    int posts;
    int k;
    do_arm(4'd4);
    n_total++;
    if ({bus.busy, bus.done} !== 2'b10) $display("FAIL pre_armed: got busy/done %b expected 10", {bus.busy, bus.done});
    else n_pass++;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if (bus.trig_addr !== 4'd9) $display("FAIL pre_trig_addr: got %0d expected 9", bus.trig_addr);
    else n_pass++;
    n_total++;
    if ({bus.ram_wen, bus.ram_addr, bus.ram_data} !== {1'b1, 4'd9, 8'd9}) $display("FAIL pre_trig_write: got wen/addr/data %b/%0d/%0d expected 1/9/9", bus.ram_wen, bus.ram_addr, bus.ram_data);
    else n_pass++;
    posts = 1;
    k = 0;
    while (!bus.done && k < 40) begin
      step(1'b0, 1'b1, 1'b0);
      k++;
      if (bus.ram_wen) posts++;
    end
    n_total++;
    if (bus.done !== 1'b1) $display("FAIL pre_done_timeout: got done %b expected 1", bus.done);
    else n_pass++;
    n_total++;
    if (posts !== 12) $display("FAIL pre_post_writes: got %0d expected 12", posts);
    else n_pass++;
    n_total++;
    if ({bus.ram_wen, bus.busy} !== 2'b10) $display("FAIL pre_done_edge: got wen/busy %b expected 10", {bus.ram_wen, bus.busy});
    else n_pass++;
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if ({bus.ram_wen, bus.done, bus.busy} !== 3'b010) $display("FAIL idle_ignore: got wen/done/busy %b expected 010", {bus.ram_wen, bus.done, bus.busy});
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      logic [7:0] exp_v;
      exp_v = (a >= 5) ? 8'(a) : 8'(a + 16);
      n_total++;
      if (mem[a] !== exp_v) $display("FAIL pre_mem[%0d]: got %0d expected %0d", a, mem[a], exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_zero_pre();
    int writes;
    int k;
    do_arm(4'd0);
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if ({bus.busy, bus.trig_addr} !== {1'b1, 4'd0}) $display("FAIL zero_trig: got busy/trig_addr %b/%0d expected 1/0", bus.busy, bus.trig_addr);
    else n_pass++;
    writes = bus.ram_wen ? 1 : 0;
    k = 0;
    while (!bus.done && k < 40) begin
      step(1'b0, 1'b1, 1'b0);
      k++;
      if (bus.ram_wen) writes++;
    end
    n_total++;
    if (writes !== 16) $display("FAIL zero_writes: got %0d expected 16", writes);
    else n_pass++;
    n_total++;
    if ({bus.done, bus.ram_wen, bus.ram_addr} !== {1'b1, 1'b1, 4'd15}) $display("FAIL zero_done_edge: got done/wen/addr %b/%b/%0d expected 1/1/15", bus.done, bus.ram_wen, bus.ram_addr);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_trig_and_abort();
    logic saw_wen;
    do_arm(4'd4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 2; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if (bus.trig_addr !== 4'd6) $display("FAIL fill_trig_addr: got %0d expected 6", bus.trig_addr);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    do_arm(4'd4);
    n_total++;
    if ({bus.busy, bus.done, bus.ram_wen} !== 3'b100) $display("FAIL post_arm: got busy/done/wen %b expected 100", {bus.busy, bus.done, bus.ram_wen});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    n_total++;
    if ({bus.ram_wen, bus.ram_addr, bus.ram_data} !== {1'b1, 4'd0, 8'd0}) $display("FAIL post_arm_restart: got wen/addr/data %b/%0d/%0d expected 1/0/0", bus.ram_wen, bus.ram_addr, bus.ram_data);
    else n_pass++;
    for (int i = 1; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if (bus.trig_addr !== 4'd4) $display("FAIL rearm_trig_addr: got %0d expected 4", bus.trig_addr);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    n_total++;
    if ({bus.busy, bus.done, bus.ram_wen} !== 3'b000) $display("FAIL post_rst: got busy/done/wen %b expected 000", {bus.busy, bus.done, bus.ram_wen});
    else n_pass++;
    saw_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (bus.ram_wen) saw_wen = 1'b1;
    end
    n_total++;
    if (saw_wen !== 1'b0) $display("FAIL post_rst_writes: got wen seen %b expected 0", saw_wen);
    else n_pass++;
  endtask

  task automatic test_long_wait();
    logic bad;
    do_arm(4'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!bus.busy || bus.done) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL long_wait_busy: got early exit %b expected 0", bad);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1);
    n_total++;
    if (bus.trig_addr !== 4'd8) $display("FAIL long_trig_addr: got %0d expected 8", bus.trig_addr);
    else n_pass++;
    n_total++;
    if (bus.ram_data !== 8'd40) $display("FAIL long_trig_data: got %0d expected 40", bus.ram_data);
    else n_pass++;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_arm_with_valid();
    bus.pre_count = 4'd2;
    cnt = 8'hff;
    step(1'b1, 1'b1, 1'b0);
    n_total++;
    if ({bus.ram_wen, bus.busy} !== 2'b01) $display("FAIL arm_valid_drop: got wen/busy %b expected 01", {bus.ram_wen, bus.busy});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    n_total++;
    if ({bus.ram_wen, bus.ram_addr, bus.ram_data} !== {1'b1, 4'd0, 8'd0}) $display("FAIL arm_valid_first: got wen/addr/data %b/%0d/%0d expected 1/0/0", bus.ram_wen, bus.ram_addr, bus.ram_data);
    else n_pass++;
  endtask

  initial begin
    bus.arm       = 1'b0;
    bus.pre_count = 4'd0;
    bus.din       = 8'd0;
    bus.din_valid = 1'b0;
    bus.trig      = 1'b0;
    test_reset();
    test_pretrig();
    test_zero_pre();
    test_fill_trig_and_abort();
    test_long_wait();
    test_arm_with_valid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
